// File: rtl/chan_select_mux_if.sv
// Handshake bundle for chan_select_mux: per-channel inputs with valid/ready,
// one registered output with valid/ready, plus the selection controls.
interface chan_select_mux_if #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/chan_select_mux.sv
// Registered N-to-1 word mux with valid/ready on every channel; explicit
// select or round-robin arbitration, one output register stage.
module chan_select_mux #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4
) (
  input logic               clk,
  input logic               rst_n,
  chan_select_mux_if.slave  mux_if
);
  localparam int unsigned SEL_W = (CHANNELS > 2) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_chan_q, out_chan_d;
  logic                out_valid_q, out_valid_d;
  logic [SEL_W-1:0]    last_q, last_d;

  logic                can_accept_c;
  logic                grant_vld_c;
  logic [SEL_W-1:0]    grant_idx_c;
  logic [WIDTH-1:0]    grant_word_c;
  logic [CHANNELS-1:0] in_ready_c;
  logic                xfer_c;

  assign can_accept_c = !out_valid_q || mux_if.out_ready;

  // Grant: explicit index, or first valid channel after last_q (wrapping).
  always_comb begin
    int unsigned idx;
    grant_vld_c = 1'b0;
    grant_idx_c = '0;
    idx         = 0;
    if (!mux_if.mode) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (SEL_W'(i) == mux_if.sel && mux_if.in_valid[i]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = SEL_W'(i);
        end
      end
    end else begin
      // Walk from farthest to nearest so the nearest valid channel wins.
      for (int k = int'(CHANNELS); k >= 1; k--) begin
        idx = 32'(last_q) + 32'(k);
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (mux_if.in_valid[idx]) begin
          grant_vld_c = 1'b1;
          grant_idx_c = SEL_W'(idx);
        end
      end
    end
  end

  always_comb begin
    grant_word_c = '0;
    in_ready_c   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (SEL_W'(i) == grant_idx_c) begin
        grant_word_c  = mux_if.in_data[i*WIDTH +: WIDTH];
        in_ready_c[i] = rst_n && can_accept_c && grant_vld_c;
      end
    end
  end

  assign xfer_c = can_accept_c && grant_vld_c;

  // Output register: fill on transfer, otherwise drain when consumer accepts.
  always_comb begin
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    last_d      = last_q;
    if (xfer_c) begin
      out_data_d  = grant_word_c;
      out_chan_d  = grant_idx_c;
      out_valid_d = 1'b1;
      last_d      = grant_idx_c;
    end else if (out_valid_q && mux_if.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
      last_q      <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
      last_q      <= last_d;
    end
  end

  assign mux_if.in_ready  = in_ready_c;
  assign mux_if.out_data  = out_data_q;
  assign mux_if.out_chan  = out_chan_q;
  assign mux_if.out_valid = out_valid_q;
endmodule

// File: doc/chan_select_mux.md
# chan_select_mux

Parametrised, registered N-to-1 datapath multiplexer with valid/ready handshaking on every input and on the output. It generalises the plain 2-to-1 word mux to CHANNELS inputs of WIDTH bits and supports two selection modes: explicit select and round-robin arbitration among valid inputs. It sits between multiple datapath producers (ALU result, load data, PC+4, immediate) and a single pipeline-register consumer. It adds one output register stage so the select path is timing-isolated.

## Interface
- WIDTH, 32, data word width in bits (>=1)
- CHANNELS, 4, number of input channels (>=2)
- SEL_W, derived localparam = max(1, clog2(CHANNELS)), select/channel-index width
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- mode  input  1  0 = explicit select, 1 = round-robin
- sel  input  SEL_W  channel index in explicit mode; ignored in round-robin
- in_data  input  CHANNELS*WIDTH  packed inputs; channel i = in_data[i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit high per cycle
- out_data  output  WIDTH  registered selected word
- out_chan  output  SEL_W  index of channel that produced out_data
- out_valid  output  1  out_data/out_chan valid
- out_ready  input  1  consumer accepts output

## Operation
- Output register: out_data, out_chan, out_valid; rr pointer `last` (SEL_W bits).
- can_accept = !out_valid || out_ready.
- Grant (combinational, at most one channel):
  - mode 0: grant = sel if sel < CHANNELS and in_valid[sel]; otherwise no grant.
  - mode 1: scan channels last+1, last+2, ... wrapping modulo CHANNELS; grant the first with in_valid set; none valid -> no grant.
- in_ready[i] = can_accept && (grant valid) && (i == grant). All others 0.
- Transfer on channel g when in_valid[g] && in_ready[g]: next edge loads out_data <= channel g word, out_chan <= g, out_valid <= 1.
- No transfer and out_ready && out_valid: out_valid <= 0; out_data/out_chan hold their last values.
- out_valid && !out_ready: all outputs hold; in_ready all 0.
- `last` updates to g only on a transfer, in either mode. Explicit-mode transfers therefore shift round-robin priority.
- A mode or sel change takes effect in the same cycle (combinational grant). It never corrupts a word already in the output register.
- Producers must hold data and valid until ready. The block does not drop or duplicate words.

## Timing
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_chan=0, last=CHANNELS-1, so channel 0 has first priority. in_ready is all 0 while rst_n is low.
- Latency: transfer at edge N -> out_valid high after edge N, same cycle visible to consumer.
- Throughput: one word per cycle when out_ready is held high.
- in_ready depends combinationally on out_ready, mode, sel, in_valid and last. There is no combinational path from in_data to any output.
- Simultaneous drain and fill (out_valid && out_ready && transfer): the new word replaces the old with no bubble.
- Reset asserted mid-transfer: the word is discarded and all state returns to reset values immediately.
- Round-robin fairness: with all CHANNELS valid continuously, each channel is granted exactly once per CHANNELS cycles.

## Test plan
- Reset: assert rst_n=0 with in_valid=all-ones, then release -> out_valid=0, out_data=0, out_chan=0, in_ready=0 during reset. First round-robin grant after release is channel 0.
- Explicit pass-through (CHANNELS=4, WIDTH=32): mode=0, sel=2, ch2=0x00000004, all valid, out_ready=1 -> only in_ready[2]=1. Next cycle out_data=0x00000004, out_chan=2. Change sel to 1 (ch1=0x00000002) -> next word 0x00000002, out_chan=1.
- Round-robin order: mode=1, all four channels valid (ch i = i+1), out_ready=1 -> out_chan sequence 0,1,2,3,0 with out_data 1,2,3,4,1. No bubbles.
- Round-robin skip: mode=1, in_valid=4'b1010 -> out_chan alternates 1,3,1,3.
- Backpressure: hold out_ready=0 for 3 cycles with out_valid=1, out_data=0x00000010 -> out_data, out_chan and out_valid are stable and in_ready=0. Raise out_ready -> the next pending word is loaded on the same edge.
- Out-of-range select (CHANNELS=3, SEL_W=2): mode=0, sel=3, all valid -> in_ready=0 and out_valid falls to 0 after the current word drains. Separately, assert rst_n=0 mid-stream -> out_valid drops immediately without a clock edge.
